// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback side bundle for the scoreboarded register file.
// master = pipeline (decode + writeback), slave = register file.
interface regfile_scoreboard_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) ();
  localparam int unsigned AW = $clog2(NREGS);

  logic [AW-1:0]    raddr1;
  logic [AW-1:0]    raddr2;
  logic [XLEN-1:0]  rdata1;
  logic [XLEN-1:0]  rdata2;
  logic             rs1_used;
  logic             rs2_used;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             reg_wr;
  logic [AW-1:0]    waddr;
  logic [XLEN-1:0]  wdata;
  logic             stall;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output raddr1, raddr2, rs1_used, rs2_used, iss_valid, iss_rd,
           reg_wr, waddr, wdata,
    input  rdata1, rdata2, stall, busy_vec
  );

  modport slave (
    input  raddr1, raddr2, rs1_used, rs2_used, iss_valid, iss_rd,
           reg_wr, waddr, wdata,
    output rdata1, rdata2, stall, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard, two async read
// ports, one write port, optional write-to-read bypass and operand stall.
module regfile_scoreboard #(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_scoreboard_if.slave   bus
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_en;
  logic             iss_fire;
  logic             byp1;
  logic             byp2;
  logic             busy_e1;
  logic             busy_e2;

  assign wr_en    = bus.reg_wr && (bus.waddr != '0);
  assign byp1     = (BYPASS != 0) && wr_en && (bus.waddr == bus.raddr1);
  assign byp2     = (BYPASS != 0) && wr_en && (bus.waddr == bus.raddr2);
  assign iss_fire = bus.iss_valid && !bus.stall && (bus.iss_rd != '0);

  // Operand written back this cycle is not considered busy when bypassed.
  always_comb begin
    busy_e1   = busy[bus.raddr1] && !byp1;
    busy_e2   = busy[bus.raddr2] && !byp2;
    bus.stall = (bus.rs1_used && busy_e1) || (bus.rs2_used && busy_e2);
  end

  always_comb begin
    bus.rdata1 = byp1 ? bus.wdata : regs[bus.raddr1];
    bus.rdata2 = byp2 ? bus.wdata : regs[bus.raddr2];
    if (bus.raddr1 == '0) bus.rdata1 = '0;
    if (bus.raddr2 == '0) bus.rdata2 = '0;
  end

  // Clear applied before set so a same-cycle issue to the written register wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)    busy_nxt[bus.waddr]  = 1'b0;
    if (iss_fire) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      busy <= busy_nxt;
      if (wr_en) regs[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks on a 32x32 instance plus randomised traffic on a 16x16
// instance compared against a behavioural reference model.
module tb_regfile_scoreboard;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) ifa ();
  regfile_scoreboard_if #(.XLEN(16), .NREGS(16)) ifb ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  regfile_scoreboard #(.XLEN(16), .NREGS(16), .BYPASS(1)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    ifa.raddr1 = '0; ifa.raddr2 = '0; ifa.rs1_used = 1'b0; ifa.rs2_used = 1'b0;
    ifa.iss_valid = 1'b0; ifa.iss_rd = '0; ifa.reg_wr = 1'b0; ifa.waddr = '0; ifa.wdata = '0;
  endtask

  // reference model for the randomised instance
  logic [15:0] m_reg [16];
  logic [15:0] m_busy;
  logic [15:0] e_r1, e_r2;
  logic        e_stall, be1, be2;

  initial begin
    idle_a();
    ifb.raddr1 = '0; ifb.raddr2 = '0; ifb.rs1_used = 1'b0; ifb.rs2_used = 1'b0;
    ifb.iss_valid = 1'b0; ifb.iss_rd = '0; ifb.reg_wr = 1'b0; ifb.waddr = '0; ifb.wdata = '0;

    // reset state
    #12;
    chk("rst_rdata1", ifa.rdata1, 32'h0);
    chk("rst_busy",   ifa.busy_vec, 32'h0);
    chk("rst_stall",  {31'b0, ifa.stall}, 32'h0);
    reset = 1'b1;
    tick();

    // write/read with bypass
    ifa.raddr1 = 5; ifa.reg_wr = 1'b1; ifa.waddr = 5; ifa.wdata = 32'hDEADBEEF;
    #1 chk("wr_bypass", ifa.rdata1, 32'hDEADBEEF);
    tick();
    ifa.reg_wr = 1'b0; ifa.wdata = '0;
    #1 chk("wr_stored", ifa.rdata1, 32'hDEADBEEF);

    // register 0 ignores writes and issues
    ifa.raddr1 = 0; ifa.raddr2 = 0; ifa.reg_wr = 1'b1; ifa.waddr = 0; ifa.wdata = 32'h1234;
    ifa.iss_valid = 1'b1; ifa.iss_rd = 0;
    #1 chk("x0_bypass", ifa.rdata1, 32'h0);
    tick();
    idle_a();
    #1 chk("x0_read", ifa.rdata2, 32'h0);
    chk("x0_busy", ifa.busy_vec, 32'h0);

    // RAW hazard on rs1
    ifa.iss_valid = 1'b1; ifa.iss_rd = 7;
    tick();
    ifa.iss_valid = 1'b0;
    chk("iss7_busy", ifa.busy_vec, 32'h0000_0080);
    ifa.raddr1 = 7; ifa.rs1_used = 1'b1;
    #1 chk("haz_stall", {31'b0, ifa.stall}, 32'h1);
    // issue while stalled is dropped
    ifa.iss_valid = 1'b1; ifa.iss_rd = 8;
    tick();
    ifa.iss_valid = 1'b0;
    chk("stall_iss_ignored", ifa.busy_vec, 32'h0000_0080);
    ifa.reg_wr = 1'b1; ifa.waddr = 7; ifa.wdata = 32'h55;
    #1 chk("wb_unstall", {31'b0, ifa.stall}, 32'h0);
    chk("wb_fwd", ifa.rdata1, 32'h55);
    tick();
    ifa.reg_wr = 1'b0;
    #1 chk("wb_busy_clr", ifa.busy_vec, 32'h0);
    chk("wb_stored", ifa.rdata1, 32'h55);

    // RAW hazard on rs2, qualified by rs2_used
    idle_a();
    ifa.iss_valid = 1'b1; ifa.iss_rd = 10;
    tick();
    ifa.iss_valid = 1'b0; ifa.raddr2 = 10; ifa.rs2_used = 1'b1;
    #1 chk("haz2_stall", {31'b0, ifa.stall}, 32'h1);
    ifa.rs2_used = 1'b0;
    #1 chk("haz2_unused", {31'b0, ifa.stall}, 32'h0);
    ifa.rs2_used = 1'b1; ifa.reg_wr = 1'b1; ifa.waddr = 10; ifa.wdata = 32'hAAAA;
    #1 chk("haz2_fwd", ifa.rdata2, 32'hAAAA);
    chk("haz2_nostall", {31'b0, ifa.stall}, 32'h0);
    tick();

    // same-cycle issue and writeback: set beats clear
    idle_a();
    ifa.iss_valid = 1'b1; ifa.iss_rd = 9; ifa.reg_wr = 1'b1; ifa.waddr = 9; ifa.wdata = 32'h99;
    tick();
    idle_a();
    ifa.raddr1 = 9;
    #1 chk("same_data", ifa.rdata1, 32'h99);
    chk("same_busy", ifa.busy_vec, 32'h0000_0200);

    // writeback to non-busy register
    ifa.reg_wr = 1'b1; ifa.waddr = 12; ifa.wdata = 32'hC0FFEE;
    tick();
    ifa.reg_wr = 1'b0; ifa.raddr2 = 12;
    #1 chk("nonbusy_data", ifa.rdata2, 32'hC0FFEE);
    chk("nonbusy_busy", ifa.busy_vec, 32'h0000_0200);

    // asynchronous reset mid-operation
    ifa.rs1_used = 1'b1;
    #1 chk("pre_rst_stall", {31'b0, ifa.stall}, 32'h1);
    reset = 1'b0;
    #1 chk("arst_rdata1", ifa.rdata1, 32'h0);
    chk("arst_rdata2", ifa.rdata2, 32'h0);
    chk("arst_busy", ifa.busy_vec, 32'h0);
    chk("arst_stall", {31'b0, ifa.stall}, 32'h0);
    #3 reset = 1'b1;
    tick();
    chk("post_rst_rdata2", ifa.rdata2, 32'h0);
    idle_a();

    // randomised traffic against the reference model
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_busy = '0;
    for (int c = 0; c < 300; c++) begin
      ifb.raddr1    = 4'($urandom_range(0, 15));
      ifb.raddr2    = 4'($urandom_range(0, 15));
      ifb.rs1_used  = 1'($urandom_range(0, 1));
      ifb.rs2_used  = 1'($urandom_range(0, 1));
      ifb.iss_valid = ($urandom_range(0, 2) == 0);
      ifb.iss_rd    = 4'($urandom_range(0, 15));
      ifb.reg_wr    = 1'($urandom_range(0, 1));
      ifb.waddr     = 4'($urandom_range(0, 15));
      ifb.wdata     = 16'($urandom);
      #1;
      e_r1 = (ifb.raddr1 == 0) ? 16'h0 :
             (ifb.reg_wr && ifb.waddr == ifb.raddr1) ? ifb.wdata : m_reg[ifb.raddr1];
      e_r2 = (ifb.raddr2 == 0) ? 16'h0 :
             (ifb.reg_wr && ifb.waddr == ifb.raddr2) ? ifb.wdata : m_reg[ifb.raddr2];
      be1 = m_busy[ifb.raddr1] && !(ifb.reg_wr && ifb.waddr == ifb.raddr1);
      be2 = m_busy[ifb.raddr2] && !(ifb.reg_wr && ifb.waddr == ifb.raddr2);
      e_stall = (ifb.rs1_used && be1) || (ifb.rs2_used && be2);
      chk("rnd_rdata1", {16'b0, ifb.rdata1}, {16'b0, e_r1});
      chk("rnd_rdata2", {16'b0, ifb.rdata2}, {16'b0, e_r2});
      chk("rnd_stall", {31'b0, ifb.stall}, {31'b0, e_stall});
      chk("rnd_busy", {16'b0, ifb.busy_vec}, {16'b0, m_busy});
      @(posedge clock);
      if (ifb.reg_wr && ifb.waddr != 0) begin
        m_reg[ifb.waddr]  = ifb.wdata;
        m_busy[ifb.waddr] = 1'b0;
      end
      if (ifb.iss_valid && !e_stall && ifb.iss_rd != 0) m_busy[ifb.iss_rd] = 1'b1;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
